// File: rtl/serializador_if.sv
// Serializer handshake/bus interface: parallel payload and load request
// toward the serializer, serial line and frame status back from it.
interface serializador_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              carga;
  logic              sal;
  logic              ocupado;
  logic              listo;

  // Producer side: supplies payload and load request, watches the line
  modport master (
    output data,
    output carga,
    input  sal,
    input  ocupado,
    input  listo
  );

  // Serializer side
  modport slave (
    input  data,
    input  carga,
    output sal,
    output ocupado,
    output listo
  );
endinterface

// File: rtl/serializador.sv
// Parallel-to-serial frame transmitter.
// Frame: start bit (0), DATA_W payload bits in MSB_FIRST order, optional
// even-parity bit, stop bit (1). Each bit holds for DIV clk cycles.
// Optional feature: define SERIALIZADOR_PARIDAD_EN to insert the parity bit
// (XOR of all payload bits) between the payload and the stop bit.
module serializador #(
  parameter int DATA_W    = 32,
  parameter int DIV       = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  serializador_if.slave bus
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  localparam logic [2:0] REPOSO  = 3'd0;
  localparam logic [2:0] INICIO  = 3'd1;
  localparam logic [2:0] DATOS   = 3'd2;
`ifdef SERIALIZADOR_PARIDAD_EN
  localparam logic [2:0] PARIDAD = 3'd3;
`endif
  localparam logic [2:0] PARADA  = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              sal_r;
  logic              ocupado_r;
  logic              listo_r;

  logic              accept;
  logic              div_end;
  logic              last_bit;
  logic              shift_en;
  logic              next_bit;

`ifdef SERIALIZADOR_PARIDAD_EN
  logic              parity;
`endif

  // Advance the payload one position toward the output end
  function automatic logic [DATA_W-1:0] shift_next(input logic [DATA_W-1:0] v);
    if (MSB_FIRST)
      shift_next = v << 1;
    else
      shift_next = v >> 1;
  endfunction

  // Load only when no frame is in progress; carga during a frame is dropped
  assign accept   = bus.carga & ~ocupado_r;
  assign div_end  = (div_cnt == DIV_LAST);
  assign last_bit = (bit_cnt == BIT_LAST);
  // Shift after the start bit and after every payload bit except the last
  assign shift_en = div_end & ((state == INICIO) | ((state == DATOS) & ~last_bit));
  assign next_bit = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];

  // Frame sequencing, bit timing and registered line/status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= REPOSO;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sal_r     <= 1'b1;
      ocupado_r <= 1'b0;
      listo_r   <= 1'b0;
    end else begin
      listo_r <= 1'b0;
      if (state != REPOSO)
        div_cnt <= div_end ? '0 : div_cnt + CNT_W'(1);
      case (state)
        REPOSO: begin
          if (accept) begin
            state     <= INICIO;
            sal_r     <= 1'b0;
            ocupado_r <= 1'b1;
            div_cnt   <= '0;
          end
        end
        INICIO: begin
          if (div_end) begin
            state   <= DATOS;
            bit_cnt <= '0;
            sal_r   <= next_bit;
          end
        end
        DATOS: begin
          if (div_end) begin
            if (last_bit) begin
`ifdef SERIALIZADOR_PARIDAD_EN
              state <= PARIDAD;
              sal_r <= parity;
`else
              state <= PARADA;
              sal_r <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              sal_r   <= next_bit;
            end
          end
        end
`ifdef SERIALIZADOR_PARIDAD_EN
        PARIDAD: begin
          if (div_end) begin
            state <= PARADA;
            sal_r <= 1'b1;
          end
        end
`endif
        PARADA: begin
          if (div_end) begin
            state     <= REPOSO;
            ocupado_r <= 1'b0;
            listo_r   <= 1'b1;
          end
        end
        default: begin
          state     <= REPOSO;
          sal_r     <= 1'b1;
          ocupado_r <= 1'b0;
        end
      endcase
    end
  end

  // Payload holding register: captured at acceptance, shifted per bit
  always_ff @(posedge clk) begin
    if (accept)
      shreg <= bus.data;
    else if (shift_en)
      shreg <= shift_next(shreg);
  end

`ifdef SERIALIZADOR_PARIDAD_EN
  // Even parity of the payload, frozen with the payload at acceptance
  always_ff @(posedge clk) begin
    if (accept)
      parity <= ^bus.data;
  end
`endif

  assign bus.sal     = sal_r;
  assign bus.ocupado = ocupado_r;
  assign bus.listo   = listo_r;

endmodule

// File: tb/tb_serializador.sv
// Scoreboard bench for serializador: three instances (8-bit DIV=4 LSB first,
// 8-bit DIV=1 MSB first, 32-bit DIV=16 LSB first). Stimulus pushes expected
// frames; one monitor per instance decodes the line and compares.
module tb_serializador;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  serializador_if #(.DATA_W(8))  if_a ();
  serializador_if #(.DATA_W(8))  if_b ();
  serializador_if #(.DATA_W(32)) if_c ();

  serializador #(.DATA_W(8), .DIV(4), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave)
  );
  serializador #(.DATA_W(8), .DIV(1), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave)
  );
  serializador #(.DATA_W(32), .DIV(16), .MSB_FIRST(1'b0)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c.slave)
  );

`ifdef SERIALIZADOR_PARIDAD_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  int cfg_w   [3] = '{8, 8, 32};
  int cfg_div [3] = '{4, 1, 16};
  int cfg_msb [3] = '{0, 1, 0};

  logic sal_v [3];
  logic ocu_v [3];
  logic lis_v [3];
  assign sal_v[0] = if_a.sal;
  assign sal_v[1] = if_b.sal;
  assign sal_v[2] = if_c.sal;
  assign ocu_v[0] = if_a.ocupado;
  assign ocu_v[1] = if_b.ocupado;
  assign ocu_v[2] = if_c.ocupado;
  assign lis_v[0] = if_a.listo;
  assign lis_v[1] = if_b.listo;
  assign lis_v[2] = if_c.listo;

  typedef struct packed {
    logic [63:0] d;
    logic        abort;
    logic        b2b;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int passes = 0;

  function automatic void chk(input bit ok, input string name,
                              input longint unsigned act, input longint unsigned req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endfunction

  function automatic void push_exp(input int id, input exp_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int q_size(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop_exp(input int id);
    case (id)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic [63:0] wmask(input int id);
    return (64'd1 << cfg_w[id]) - 64'd1;
  endfunction

  // Reference model: number of bits in a frame
  function automatic int nbits(input int id);
    return cfg_w[id] + 2 + PAR;
  endfunction

  // Reference model: value of frame bit k for payload d
  function automatic bit exp_bit(input int id, input logic [63:0] d, input int k);
    int w;
    bit p;
    w = cfg_w[id];
    if (k == 0) return 1'b0;
    if (k <= w) return d[(cfg_msb[id] != 0) ? (w - k) : (k - 1)];
    if (PAR == 1 && k == w + 1) begin
      p = 1'b0;
      for (int i = 0; i < w; i++) p = p ^ d[i];
      return p;
    end
    return 1'b1;
  endfunction

  task automatic monitor(input int id);
    bit          prev     = 1'b0;
    bit          have     = 1'b0;
    bit          lis_in   = 1'b0;
    bit          lis_next = 1'b0;
    int          idle     = 1000;
    int          n;
    int          bad;
    int          j;
    logic [63:0] rec;
    bit          tr[$];
    exp_t        cur;
    cur = '0;
    forever begin
      @(negedge clk);
      if (lis_next) begin
        chk(lis_v[id] == 1'b0, $sformatf("u%0d_listo_width", id), lis_v[id], 0);
        lis_next = 1'b0;
      end
      if (ocu_v[id] && !prev) begin
        tr.delete();
        lis_in = 1'b0;
        if (q_size(id) == 0) begin
          have = 1'b0;
          chk(1'b0, $sformatf("u%0d_unexpected_frame", id), 1, 0);
        end else begin
          cur  = pop_exp(id);
          have = 1'b1;
          if (cur.b2b) chk(idle == 1, $sformatf("u%0d_b2b_gap", id), idle, 1);
        end
      end
      if (ocu_v[id]) begin
        tr.push_back(sal_v[id]);
        if (lis_v[id]) lis_in = 1'b1;
      end else if (prev) begin
        idle     = 1;
        lis_next = 1'b1;
        if (have) begin
          chk(sal_v[id] == 1'b1, $sformatf("u%0d_idle_high", id), sal_v[id], 1);
          if (cur.abort) begin
            chk(lis_v[id] == 1'b0, $sformatf("u%0d_abort_no_listo", id), lis_v[id], 0);
          end else begin
            n = nbits(id) * cfg_div[id];
            chk(tr.size() == n, $sformatf("u%0d_frame_len", id), tr.size(), n);
            bad = -1;
            for (int k = 0; k < tr.size() && k < n; k++)
              if (bad < 0 && tr[k] != exp_bit(id, cur.d, k / cfg_div[id])) bad = k;
            chk(bad < 0, $sformatf("u%0d_bits_cycle%0d", id, bad),
                (bad < 0) ? 0 : tr[bad], (bad < 0) ? 0 : exp_bit(id, cur.d, bad / cfg_div[id]));
            rec = '0;
            for (int k = 1; k <= cfg_w[id]; k++) begin
              j = k * cfg_div[id] + cfg_div[id] / 2;
              if (j < tr.size()) rec[(cfg_msb[id] != 0) ? (cfg_w[id] - k) : (k - 1)] = tr[j];
            end
            chk(rec == cur.d, $sformatf("u%0d_payload", id), rec, cur.d);
            chk(lis_in == 1'b0, $sformatf("u%0d_listo_early", id), lis_in, 0);
            chk(lis_v[id] == 1'b1, $sformatf("u%0d_listo_pulse", id), lis_v[id], 1);
          end
        end
      end else begin
        idle++;
      end
      prev = ocu_v[id];
    end
  endtask

  task automatic drive(input int id, input logic [63:0] d, input bit c);
    case (id)
      0: begin if_a.data = d[7:0];  if_a.carga = c; end
      1: begin if_b.data = d[7:0];  if_b.carga = c; end
      default: begin if_c.data = d[31:0]; if_c.carga = c; end
    endcase
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    while (ocu_v[id] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (ocu_v[id]) chk(1'b0, $sformatf("u%0d_timeout_idle", id), n, 3000);
  endtask

  task automatic send(input int id, input logic [63:0] d, input bit abort);
    exp_t e;
    wait_idle(id);
    e.d     = d & wmask(id);
    e.abort = abort;
    e.b2b   = 1'b0;
    push_exp(id, e);
    drive(id, d, 1'b1);
    @(negedge clk);
    drive(id, d, 1'b0);
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  initial begin
    exp_t e;
    int   n;
    drive(0, 0, 1'b0);
    drive(1, 0, 1'b0);
    drive(2, 0, 1'b0);
    #1 reset = 1'b1;
    #1;
    for (int id = 0; id < 3; id++) begin
      chk(sal_v[id] == 1'b1, $sformatf("u%0d_reset_sal", id), sal_v[id], 1);
      chk(ocu_v[id] == 1'b0, $sformatf("u%0d_reset_ocupado", id), ocu_v[id], 0);
      chk(lis_v[id] == 1'b0, $sformatf("u%0d_reset_listo", id), lis_v[id], 0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Unit A: fixed vectors then random payloads
    send(0, 64'hA5, 1'b0);
    send(0, 64'h07, 1'b0);
    for (int i = 0; i < 4; i++) send(0, 64'($urandom), 1'b0);

    // Unit A: carga held high, data changes mid-frame
    wait_idle(0);
    e.d = 64'h11; e.abort = 1'b0; e.b2b = 1'b0;
    push_exp(0, e);
    e.d = 64'h22; e.b2b = 1'b1;
    push_exp(0, e);
    drive(0, 64'h11, 1'b1);
    repeat (6) @(negedge clk);
    drive(0, 64'h33, 1'b1);
    repeat (14) @(negedge clk);
    drive(0, 64'h22, 1'b1);
    n = 0;
    while (!lis_v[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!lis_v[0]) chk(1'b0, "u0_timeout_listo", n, 200);
    @(negedge clk);
    drive(0, 64'h22, 1'b0);

    // Unit A: reset in the 13th cycle of a frame, carga held during reset
    send(0, 64'($urandom), 1'b1);
    repeat (12) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk(sal_v[0] == 1'b1, "u0_abort_sal", sal_v[0], 1);
    chk(ocu_v[0] == 1'b0, "u0_abort_ocupado", ocu_v[0], 0);
    chk(lis_v[0] == 1'b0, "u0_abort_listo", lis_v[0], 0);
    drive(0, 64'h3C, 1'b1);
    repeat (2) @(negedge clk);
    drive(0, 64'h3C, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk(ocu_v[0] == 1'b0, "u0_carga_in_reset_ignored", ocu_v[0], 0);
    send(0, 64'h5A, 1'b0);

    // Unit B: MSB first, one cycle per bit
    send(1, 64'h80, 1'b0);
    for (int i = 0; i < 3; i++) send(1, 64'($urandom), 1'b0);

    // Unit C: 32-bit payload, 16 cycles per bit
    send(2, 64'hDEADBEEF, 1'b0);
    send(2, 64'($urandom), 1'b0);

    for (int k = 0; k < 4000; k++) begin
      if (q_size(0) + q_size(1) + q_size(2) == 0 && !ocu_v[0] && !ocu_v[1] && !ocu_v[2]) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    for (int id = 0; id < 3; id++)
      chk(q_size(id) == 0, $sformatf("u%0d_drain", id), q_size(id), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
